// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  localparam int unsigned MULDIV_XLEN = 32;
  localparam int unsigned CNT_W       = $clog2(MULDIV_XLEN);

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_e;

  function automatic logic op_is_div(input muldiv_op_e o);
    return (o == OP_DIV) || (o == OP_DIVU) || (o == OP_REM) || (o == OP_REMU);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative engine: one shift-add multiply step or one restoring-divide step per cycle
// on unsigned magnitudes held in a hi/lo register pair.
module muldiv_datapath #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            is_div_i,
  input  logic [XLEN-1:0] opnd_i,
  input  logic [XLEN-1:0] lo_init_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [XLEN-1:0] addend;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // Mul: lo holds the multiplier, shifted out LSB-first while the product grows into hi.
  // Div: lo holds the dividend, shifted out MSB-first while quotient bits shift in.
  always_comb begin
    addend  = lo_q[0] ? opnd_q : '0;
    sum     = {1'b0, hi_q} + {1'b0, addend};
    shifted = {hi_q, lo_q[XLEN-1]};
    diff    = shifted - {1'b0, opnd_q};
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    if (load_i) begin
      hi_d   = '0;
      lo_d   = lo_init_i;
      opnd_d = opnd_i;
    end else if (step_i) begin
      if (is_div_i) begin
        hi_d = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], ~diff[XLEN]};
      end else begin
        hi_d = sum[XLEN:1];
        lo_d = {sum[0], lo_q[XLEN-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle multiply/divide sequencer: accepts one op from EX, stalls the front
// of the pipeline while iterating, then presents a sign-corrected result for one cycle.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN      = MULDIV_XLEN,
  parameter bit          FAST_ZERO = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN);

  muldiv_state_e   state_q, state_d;
  muldiv_op_e      op_q, op_d, op_in;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] a_mag_q, a_mag_d;
  logic            sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic            b_zero_q, b_zero_d, fast_q, fast_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            sa, sb, skip, load, step;
  logic [XLEN-1:0] a_mag, b_mag, dp_hi, dp_lo;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0] mul_res, quo, rem_mag, rem, fix_res;

  always_comb begin
    op_in = muldiv_op_e'(op);
    sa    = rs1_data[XLEN-1] & (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    sb    = rs2_data[XLEN-1] & (op_in inside {OP_MULH, OP_DIV, OP_REM});
    a_mag = sa ? -rs1_data : rs1_data;
    b_mag = sb ? -rs2_data : rs2_data;
    skip  = FAST_ZERO && ((rs2_data == '0) || (!op_is_div(op_in) && (rs1_data == '0)));
  end

  muldiv_datapath #(.XLEN(XLEN)) u_datapath (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .step_i   (step),
    .is_div_i (op_is_div(op_q)),
    .opnd_i   (op_is_div(op_in) ? b_mag : a_mag),
    .lo_init_i(op_is_div(op_in) ? a_mag : b_mag),
    .hi_o     (dp_hi),
    .lo_o     (dp_lo)
  );

  // Division by zero bypasses the iterated quotient/remainder so both the fast and the
  // iterated paths yield all-ones and A; a skipped multiply is always zero.
  always_comb begin
    prod     = {dp_hi, dp_lo};
    prod_fix = (sign_a_q ^ sign_b_q) ? -prod : prod;
    if (fast_q)
      mul_res = '0;
    else if (op_q == OP_MUL)
      mul_res = prod_fix[XLEN-1:0];
    else
      mul_res = prod_fix[2*XLEN-1:XLEN];
    quo      = b_zero_q ? '1 : ((sign_a_q ^ sign_b_q) ? -dp_lo : dp_lo);
    rem_mag  = b_zero_q ? a_mag_q : dp_hi;
    rem      = sign_a_q ? -rem_mag : rem_mag;
    if (!op_is_div(op_q))
      fix_res = mul_res;
    else if (op_q inside {OP_DIV, OP_DIVU})
      fix_res = quo;
    else
      fix_res = rem;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    a_mag_d  = a_mag_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    b_zero_d = b_zero_q;
    fast_d   = fast_q;
    result_d = result_q;
    load     = 1'b0;
    step     = 1'b0;
    stall    = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          stall    = 1'b1;
          load     = 1'b1;
          op_d     = op_in;
          a_mag_d  = a_mag;
          sign_a_d = sa;
          sign_b_d = sb;
          b_zero_d = (rs2_data == '0);
          fast_d   = skip;
          cnt_d    = CW'(XLEN - 1);
          state_d  = skip ? FIX : CALC;
        end
      end
      CALC: begin
        stall = 1'b1;
        if (flush) begin
          state_d = IDLE;
        end else begin
          step = 1'b1;
          if (cnt_q == '0) state_d = FIX;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      FIX: begin
        stall = 1'b1;
        if (flush) begin
          state_d = IDLE;
        end else begin
          result_d = fix_res;
          state_d  = DONE;
        end
      end
      DONE: begin
        done    = !flush;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= OP_MUL;
      cnt_q    <= '0;
      a_mag_q  <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      b_zero_q <= 1'b0;
      fast_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      a_mag_q  <= a_mag_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      b_zero_q <= b_zero_d;
      fast_q   <= fast_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed RV32M vectors, randomized ops against
// an arithmetic reference model, back-to-back issue, flush and mid-operation reset.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic        flush = 1'b0;
  logic        stall, busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.XLEN(32), .FAST_ZERO(1'b1)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .rs1_data(rs1_data),
    .rs2_data(rs2_data),
    .flush   (flush),
    .stall   (stall),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  // RV32M semantics computed with 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (o)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  // Cycles from the start cycle (index 0) to the done cycle; also the number of stall cycles.
  function automatic int exp_latency(input logic [2:0] o, input logic [31:0] a,
                                     input logic [31:0] b);
    if (b == 0 || (o < 3'd4 && a == 0)) return 2;
    return 34;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      default: return $urandom();
    endcase
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int done_idx, output int stall_cnt);
    @(posedge clk); #1;
    start = 1'b1; op = o; rs1_data = a; rs2_data = b; flush = 1'b0;
    done_idx = -1; stall_cnt = 0; res = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (stall) stall_cnt++;
      if (done) begin
        done_idx = i;
        res = result;
        break;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", result); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  logic [2:0]  d_op  [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
  logic [31:0] d_a   [12] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                              32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] d_b   [12] = '{32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2, 32'd7, 32'd7,
                              32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] d_exp [12] = '{32'h0000_002A, 32'h0000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                              32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5,
                              32'h8000_0000, 32'h0000_0000};

  task automatic test_directed();
    logic [31:0] res;
    int di, sc, lat;
    for (int k = 0; k < 12; k++) begin
      run_op(d_op[k], d_a[k], d_b[k], res, di, sc);
      lat = (d_b[k] == 0) ? 2 : 34;
      checks++; if (res !== d_exp[k]) begin errors++; $display("FAIL directed_result[%0d]: got %h expected %h", k, res, d_exp[k]); end
      checks++; if (di != lat) begin errors++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", k, di, lat); end
      checks++; if (sc != lat) begin errors++; $display("FAIL directed_stall_cycles[%0d]: got %0d expected %0d", k, sc, lat); end
      @(negedge clk);
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL directed_done_pulse[%0d]: got done=%b busy=%b expected 0 0", k, done, busy); end
    end
  endtask

  task automatic test_random();
    logic [2:0] o;
    logic [31:0] a, b, res, exp_r;
    int di, sc, lat;
    for (int k = 0; k < 60; k++) begin
      o = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      exp_r = ref_model(o, a, b);
      lat = exp_latency(o, a, b);
      run_op(o, a, b, res, di, sc);
      checks++; if (res !== exp_r) begin errors++; $display("FAIL random_result op=%0d a=%h b=%h: got %h expected %h", o, a, b, res, exp_r); end
      checks++; if (di != lat) begin errors++; $display("FAIL random_latency op=%0d a=%h b=%h: got %0d expected %0d", o, a, b, di, lat); end
      checks++; if (sc != lat) begin errors++; $display("FAIL random_stall op=%0d a=%h b=%h: got %0d expected %0d", o, a, b, sc, lat); end
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    logic [31:0] r1, r2;
    logic stall_at_done, first_stall;
    d1 = -1; d2 = -1; r1 = '0; r2 = '0; stall_at_done = 1'b1; first_stall = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; op = 3'd0; rs1_data = 32'd3; rs2_data = 32'd5;
    // start stays high with a different op while busy and in DONE; it must be ignored
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin d1 = i; r1 = result; stall_at_done = stall; break; end
      @(posedge clk); #1;
      op = 3'd5; rs1_data = 32'd100; rs2_data = 32'd7;
    end
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 0) first_stall = stall;
      if (done) begin d2 = i; r2 = result; break; end
    end
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (d1 != 34) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 34", d1); end
    checks++; if (r1 !== 32'd15) begin errors++; $display("FAIL b2b_first_result: got %h expected 0000000f", r1); end
    checks++; if (stall_at_done !== 1'b0) begin errors++; $display("FAIL b2b_stall_in_done: got %b expected 0", stall_at_done); end
    checks++; if (first_stall !== 1'b1) begin errors++; $display("FAIL b2b_second_accept_stall: got %b expected 1", first_stall); end
    checks++; if (d2 != 34) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 34", d2); end
    checks++; if (r2 !== 32'd14) begin errors++; $display("FAIL b2b_second_result: got %h expected 0000000e", r2); end
  endtask

  task automatic test_flush_and_reset();
    logic [31:0] res;
    int di, sc;
    logic seen_done;
    run_op(3'd0, 32'd7, 32'd6, res, di, sc);
    checks++; if (res !== 32'h2A) begin errors++; $display("FAIL flush_prior_result: got %h expected 0000002a", res); end

    @(posedge clk); #1;
    start = 1'b1; op = 3'd0; rs1_data = 32'd1234; rs2_data = 32'd5678;
    repeat (10) begin @(posedge clk); #1; start = 1'b0; end
    flush = 1'b1;
    @(negedge clk);
    checks++; if (stall !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL flush_cycle_stall: got stall=%b busy=%b expected 1 1", stall, busy); end
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    checks++; if (stall !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL flush_next_stall: got stall=%b busy=%b expected 0 0", stall, busy); end
    seen_done = 1'b0;
    repeat (40) begin @(negedge clk); if (done) seen_done = 1'b1; end
    checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL flush_no_done: got %b expected 0", seen_done); end
    checks++; if (result !== 32'h2A) begin errors++; $display("FAIL flush_result_kept: got %h expected 0000002a", result); end

    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; op = 3'd0; rs1_data = 32'd3; rs2_data = 32'd3;
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL idle_flush_stall: got %b expected 0", stall); end
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_flush_no_accept: got %b expected 0", busy); end

    @(posedge clk); #1;
    start = 1'b1; op = 3'd4; rs1_data = 32'd1000; rs2_data = 32'd7;
    repeat (5) begin @(posedge clk); #1; start = 1'b0; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (stall !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midop_reset_ctrl: got stall=%b busy=%b done=%b expected 0 0 0", stall, busy, done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL midop_reset_result: got %h expected 00000000", result); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_flush_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
